// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multi-cycle RV32I controller and the shared
// instruction/data memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB against a
// shared memory, traps illegal opcodes and memory timeouts, counts cycles and retirements.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    mem_if,
  input  logic [6:0]           opcode_i,
  input  logic                 bcond_i,
  input  logic                 halt_req_i,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic [1:0]           pc_source_o,
  output logic                 reg_write_o,
  output logic [1:0]           wb_sel_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_class_o,
  output logic [2:0]           state_o,
  output logic                 is_halted_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] cycle_count_o,
  output logic [CNT_WIDTH-1:0] retire_count_o
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5,
    ST_ERR  = 3'd6,
    ST_BAD  = 3'd7
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  logic [7:0]           wait_q, wait_d, wait_inc_s;
  logic                 halted_q, error_q;
  logic [CNT_WIDTH-1:0] cycle_q, retire_q;
  logic                 mem_req_s, mem_write_s, i_or_d_s, ir_write_s;
  logic                 pc_write_s, reg_write_s, alu_src_a_s, retire_s;
  logic [1:0]           pc_source_s, wb_sel_s, alu_src_b_s, alu_class_s;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  assign wait_inc_s = wait_q + 8'd1;

  // Next-state and control decode; ready wins over a timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    wait_d      = 8'd0;
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    i_or_d_s    = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    pc_source_s = 2'd0;
    reg_write_s = 1'b0;
    wb_sel_s    = 2'd0;
    alu_src_a_s = 1'b0;
    alu_src_b_s = 2'd0;
    alu_class_s = 2'd0;
    retire_s    = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_req_s = 1'b1;
        if (mem_if.mem_ready) begin
          ir_write_s = 1'b1;
          state_d    = ST_ID;
        end else if (wait_inc_s == TIMEOUT_C) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      ST_ID: begin
        if (opcode_i == OP_SYS) begin
          if (halt_req_i) begin
            state_d = ST_HALT;
          end else begin
            pc_write_s = 1'b1;
            retire_s   = 1'b1;
            state_d    = ST_IF;
          end
        end else if (is_legal(opcode_i)) begin
          state_d = ST_EX;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_EX: begin
        case (opcode_i)
          OP_R: begin
            alu_class_s = 2'd2;
            state_d     = ST_WB;
          end
          OP_I: begin
            alu_src_b_s = 2'd1;
            alu_class_s = 2'd2;
            state_d     = ST_WB;
          end
          OP_LUI: begin
            alu_src_b_s = 2'd1;
            state_d     = ST_WB;
          end
          OP_AUIPC: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'd1;
            state_d     = ST_WB;
          end
          OP_LD, OP_ST: begin
            alu_src_b_s = 2'd1;
            state_d     = ST_MEM;
          end
          OP_BR: begin
            alu_class_s = 2'd1;
            pc_write_s  = 1'b1;
            if (bcond_i) begin
              pc_source_s = 2'd1;
            end else begin
              pc_source_s = 2'd0;
            end
            retire_s = 1'b1;
            state_d  = ST_IF;
          end
          OP_JAL: begin
            reg_write_s = 1'b1;
            wb_sel_s    = 2'd2;
            pc_write_s  = 1'b1;
            pc_source_s = 2'd1;
            retire_s    = 1'b1;
            state_d     = ST_IF;
          end
          OP_JALR: begin
            alu_src_b_s = 2'd1;
            reg_write_s = 1'b1;
            wb_sel_s    = 2'd2;
            pc_write_s  = 1'b1;
            pc_source_s = 2'd2;
            retire_s    = 1'b1;
            state_d     = ST_IF;
          end
          default: state_d = ST_ERR;
        endcase
      end
      ST_MEM: begin
        mem_req_s   = 1'b1;
        i_or_d_s    = 1'b1;
        mem_write_s = (opcode_i == OP_ST);
        if (mem_if.mem_ready) begin
          if (opcode_i == OP_ST) begin
            pc_write_s = 1'b1;
            retire_s   = 1'b1;
            state_d    = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_inc_s == TIMEOUT_C) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      ST_WB: begin
        reg_write_s = 1'b1;
        if (opcode_i == OP_LD) begin
          wb_sel_s = 2'd1;
        end else begin
          wb_sel_s = 2'd0;
        end
        pc_write_s = 1'b1;
        retire_s   = 1'b1;
        state_d    = ST_IF;
      end
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // State register and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IF;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Sticky halt/error flags, set as the FSM enters the terminal state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      halted_q <= halted_q | (state_d == ST_HALT);
      error_q  <= error_q | (state_d == ST_ERR);
    end
  end

  // Performance counters; frozen in HALT/ERR and the unreachable encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (state_q <= ST_WB) begin
        cycle_q <= cycle_q + CNT_WIDTH'(1);
      end
      if (retire_s) begin
        retire_q <= retire_q + CNT_WIDTH'(1);
      end
    end
  end

  // Gating with rst_n forces every control output low the instant reset asserts.
  assign mem_if.mem_req   = mem_req_s & rst_n;
  assign mem_if.mem_write = mem_write_s & rst_n;
  assign mem_if.i_or_d    = i_or_d_s & rst_n;
  assign ir_write_o       = ir_write_s & rst_n;
  assign pc_write_o       = pc_write_s & rst_n;
  assign pc_source_o      = pc_source_s & {2{rst_n}};
  assign reg_write_o      = reg_write_s & rst_n;
  assign wb_sel_o         = wb_sel_s & {2{rst_n}};
  assign alu_src_a_o      = alu_src_a_s & rst_n;
  assign alu_src_b_o      = alu_src_b_s & {2{rst_n}};
  assign alu_class_o      = alu_class_s & {2{rst_n}};
  assign state_o          = state_q;
  assign is_halted_o      = halted_q;
  assign error_o          = error_q;
  assign cycle_count_o    = cycle_q;
  assign retire_count_o   = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction is expanded
// into an expected per-cycle trace from its class and memory delays, then replayed.
module tb_multicycle_ctrl;
  localparam int TMO = 15;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        bcond, halt_req;
  logic        ir_write, pc_write, reg_write, alu_src_a, is_halted, error;
  logic [1:0]  pc_source, wb_sel, alu_src_b, alu_class;
  logic [2:0]  state;
  logic [31:0] cycle_count, retire_count;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_if(mif),
    .opcode_i(opcode), .bcond_i(bcond), .halt_req_i(halt_req),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_source_o(pc_source),
    .reg_write_o(reg_write), .wb_sel_o(wb_sel), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_class_o(alu_class), .state_o(state),
    .is_halted_o(is_halted), .error_o(error),
    .cycle_count_o(cycle_count), .retire_count_o(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, wr, iod, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wbs;
    logic       asa;
    logic [1:0] asb, acl;
    logic       hlt, err;
  } exp_t;

  typedef struct {
    exp_t e;
    bit   ready;
    bit   retire;
  } cyc_t;

  cyc_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cyc, exp_ret;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] obs();
    return {state, mif.mem_req, mif.mem_write, mif.i_or_d, ir_write, pc_write, pc_source,
            reg_write, wb_sel, alu_src_a, alu_src_b, alu_class, is_halted, error};
  endfunction

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c.e     = '0;
    c.e.st  = st;
    c.e.hlt = (st == 3'd5);
    c.e.err = (st == 3'd6);
    c.ready = 1'b0;
    c.retire = 1'b0;
    return c;
  endfunction

  task automatic add_wait(input logic [2:0] st, input bit wr, input int delay, output bit timed_out);
    cyc_t c;
    c = blank(st);
    c.e.req = 1'b1;
    c.e.iod = (st == 3'd3);
    c.e.wr  = wr;
    timed_out = (delay >= TMO);
    for (int k = 0; k < (timed_out ? TMO : delay); k++) q.push_back(c);
    if (!timed_out) begin
      c.ready = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic add_term(input logic [2:0] st, input int n);
    for (int k = 0; k < n; k++) q.push_back(blank(st));
  endtask

  task automatic add_wb(input bit ld);
    cyc_t c;
    c = blank(3'd4);
    c.e.rw  = 1'b1;
    c.e.wbs = ld ? 2'd1 : 2'd0;
    c.e.pcw = 1'b1;
    c.retire = 1'b1;
    q.push_back(c);
  endtask

  task automatic build(input logic [6:0] op, input bit bc, input bit hr,
                       input int d_if, input int d_mem, output bit term);
    cyc_t c;
    bit   to;
    term = 1'b0;
    add_wait(3'd0, 1'b0, d_if, to);
    if (to) begin add_term(3'd6, 4); term = 1'b1; return; end
    c = q.pop_back(); c.e.irw = 1'b1; q.push_back(c);
    c = blank(3'd1);
    if (op == OP_SYS) begin
      if (hr) begin q.push_back(c); add_term(3'd5, 10); term = 1'b1; return; end
      c.e.pcw = 1'b1; c.retire = 1'b1; q.push_back(c);
      return;
    end
    if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})) begin
      q.push_back(c); add_term(3'd6, 4); term = 1'b1; return;
    end
    q.push_back(c);
    c = blank(3'd2);
    case (op)
      OP_R:     begin c.e.acl = 2'd2; q.push_back(c); add_wb(1'b0); end
      OP_I:     begin c.e.asb = 2'd1; c.e.acl = 2'd2; q.push_back(c); add_wb(1'b0); end
      OP_LUI:   begin c.e.asb = 2'd1; q.push_back(c); add_wb(1'b0); end
      OP_AUIPC: begin c.e.asb = 2'd1; c.e.asa = 1'b1; q.push_back(c); add_wb(1'b0); end
      OP_LD: begin
        c.e.asb = 2'd1; q.push_back(c);
        add_wait(3'd3, 1'b0, d_mem, to);
        if (to) begin add_term(3'd6, 4); term = 1'b1; return; end
        add_wb(1'b1);
      end
      OP_ST: begin
        c.e.asb = 2'd1; q.push_back(c);
        add_wait(3'd3, 1'b1, d_mem, to);
        if (to) begin add_term(3'd6, 4); term = 1'b1; return; end
        c = q.pop_back(); c.e.pcw = 1'b1; c.retire = 1'b1; q.push_back(c);
      end
      OP_BR: begin
        c.e.acl = 2'd1; c.e.pcw = 1'b1; c.e.pcs = bc ? 2'd1 : 2'd0; c.retire = 1'b1;
        q.push_back(c);
      end
      OP_JAL: begin
        c.e.rw = 1'b1; c.e.wbs = 2'd2; c.e.pcw = 1'b1; c.e.pcs = 2'd1; c.retire = 1'b1;
        q.push_back(c);
      end
      default: begin
        c.e.asb = 2'd1; c.e.rw = 1'b1; c.e.wbs = 2'd2; c.e.pcw = 1'b1; c.e.pcs = 2'd2;
        c.retire = 1'b1;
        q.push_back(c);
      end
    endcase
  endtask

  // Replays up to 'limit' expected cycles; entered and left at posedge+1.
  task automatic run(input int limit);
    cyc_t c;
    int   n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      c = q.pop_front();
      mif.mem_ready = c.ready;
      @(negedge clk);
      check_val($sformatf("outputs st%0d", c.e.st), 64'(obs()), 64'(c.e));
      check_val("cycle_count", 64'(cycle_count), 64'(exp_cyc));
      check_val("retire_count", 64'(retire_count), 64'(exp_ret));
      if (c.e.st <= 3'd4) exp_cyc = exp_cyc + 32'd1;
      if (c.retire) exp_ret = exp_ret + 32'd1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    check_val("reset outputs", 64'(obs()), 64'd0);
    check_val("reset counters", {cycle_count, retire_count}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cyc = 32'd0;
    exp_ret = 32'd0;
    q.delete();
  endtask

  task automatic do_instr(input logic [6:0] op, input bit bc, input bit hr, input int di, input int dm);
    bit term;
    opcode = op; bcond = bc; halt_req = hr;
    q.delete();
    build(op, bc, hr, di, dm, term);
    run(1000);
    if (term) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops[10];
    int         idx;
    bit         hr;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS};
    rst_n = 1'b1; opcode = 7'd0; bcond = 1'b0; halt_req = 1'b0; mif.mem_ready = 1'b0;
    #2;
    do_reset();

    do_instr(OP_R, 1'b0, 1'b0, 0, 0);
    check_val("add cycle_count", 64'(cycle_count), 64'd4);
    check_val("add retire_count", 64'(retire_count), 64'd1);
    do_instr(OP_LD, 1'b0, 1'b0, 3, 3);
    do_instr(OP_BR, 1'b1, 1'b0, 0, 0);
    do_instr(OP_BR, 1'b0, 1'b0, 1, 0);
    do_instr(OP_ST, 1'b0, 1'b0, 2, 1);
    do_instr(OP_JAL, 1'b0, 1'b0, 0, 0);
    do_instr(OP_JALR, 1'b1, 1'b1, 0, 0);
    do_instr(OP_LUI, 1'b0, 1'b0, 0, 0);
    do_instr(OP_AUIPC, 1'b0, 1'b0, 0, 0);
    do_instr(OP_I, 1'b0, 1'b0, 0, 0);
    do_instr(OP_SYS, 1'b0, 1'b0, 0, 0);
    do_instr(OP_LD, 1'b0, 1'b0, TMO - 1, TMO - 1);
    do_instr(OP_ST, 1'b0, 1'b0, TMO - 1, TMO - 1);

    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 9);
      hr  = (ops[idx] == OP_SYS) ? 1'b0 : 1'($urandom_range(0, 1));
      do_instr(ops[idx], 1'($urandom_range(0, 1)), hr,
               ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 3),
               $urandom_range(0, 4));
    end

    do_instr(OP_SYS, 1'b0, 1'b1, 1, 0);
    do_instr(OP_R, 1'b0, 1'b0, TMO, 0);
    do_instr(OP_LD, 1'b0, 1'b0, 0, TMO + 3);
    do_instr(7'b0000000, 1'b0, 1'b0, 0, 0);

    // Abort a store while it waits in MEM.
    begin
      bit term;
      opcode = OP_ST; bcond = 1'b0; halt_req = 1'b0;
      q.delete();
      build(OP_ST, 1'b0, 1'b0, 0, 5, term);
      run(4);
      mif.mem_ready = 1'b0;
      #2;
      check_val("store mem_write pre-reset", 64'(mif.mem_write), 64'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid-store reset outputs", 64'(obs()), 64'd0);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_cyc = 32'd0;
      exp_ret = 32'd0;
    end
    do_instr(OP_R, 1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle RV32I core; the next generation of the single-cycle datapath.
- Sequences each instruction through IF/ID/EX/MEM/WB over several cycles against a shared instruction/data memory with a ready handshake.
- Detects the ecall halt condition (x17 == 10), traps illegal opcodes and memory timeouts, and keeps cycle and retired-instruction counters.

Parameters:
- MEM_TIMEOUT, 15, max consecutive cycles mem_req may wait for mem_ready before the FSM enters ERR; legal range 1..255.
- CNT_WIDTH, 32, width of cycle_count and retire_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  opcode field of the registered IR.
- bcond  input  1  branch-taken result from the ALU, already resolved against funct3.
- halt_req  input  1  high when x17 == 10.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  store when mem_req is high.
- i_or_d  output  1  0 = fetch at PC, 1 = data at ALUOut.
- ir_write  output  1  load the IR.
- pc_write  output  1  update the PC.
- pc_source  output  2  0 = PC+4, 1 = PC+imm, 2 = ALU result (jalr).
- reg_write  output  1  register-file write enable.
- wb_sel  output  2  0 = ALU, 1 = MDR, 2 = PC+4.
- alu_src_a  output  1  0 = rs1, 1 = PC.
- alu_src_b  output  2  0 = rs2, 1 = imm, 2 = constant 4.
- alu_class  output  2  0 = add, 1 = sub/compare, 2 = funct-decoded.
- state  output  3  current state encoding.
- is_halted  output  1  sticky halt flag.
- error  output  1  sticky error flag.
- cycle_count  output  CNT_WIDTH  cycles since reset, excluding HALT/ERR.
- retire_count  output  CNT_WIDTH  retired instructions.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6. Value 7 is unreachable; if entered, it goes to ERR next cycle.
- Reset (reset low, asynchronous): state=IF, wait counter=0, both count registers=0, is_halted=0, error=0.
- While reset is asserted, all control outputs are 0. The first cycle after reset deasserts is IF.
- Outputs are decoded combinationally from state and opcode; all outputs not listed for a state are 0.
- IF:
  - mem_req=1, i_or_d=0.
  - On mem_ready: ir_write=1, go to ID.
  - Otherwise the wait counter increments; on reaching MEM_TIMEOUT, go to ERR.
- ID:
  - ecall (1110011) with halt_req=1: go to HALT; the ecall is not retired.
  - ecall with halt_req=0: treated as nop; pc_write=1, pc_source=0, retire, go to IF.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}: go to ERR.
  - Otherwise go to EX.
- EX:
  - R-type: alu_src_b=0, alu_class=2, go to WB.
  - I-ALU: alu_src_b=1, alu_class=2, go to WB.
  - lui/auipc: alu_src_b=1, alu_class=0, alu_src_a=1 for auipc, go to WB.
  - load/store: alu_src_b=1, alu_class=0, go to MEM.
  - branch: alu_class=1, pc_write=1, pc_source = bcond ? 1 : 0, retire, go to IF.
  - jal: reg_write=1, wb_sel=2, pc_write=1, pc_source=1, retire, go to IF.
  - jalr: alu_src_b=1, alu_class=0, reg_write=1, wb_sel=2, pc_write=1, pc_source=2, retire, go to IF.
- MEM:
  - mem_req=1, i_or_d=1, mem_write=1 for stores. Timeout rule is the same as IF.
  - On mem_ready for a store: pc_write=1, pc_source=0, retire, go to IF.
  - On mem_ready for a load: go to WB.
- WB: reg_write=1, wb_sel=1 for load else 0, pc_write=1, pc_source=0, retire, go to IF.
- Wait counter: cleared on every state change; never exceeds MEM_TIMEOUT. mem_ready in the same cycle the counter reaches MEM_TIMEOUT completes normally; ready wins.
- HALT: is_halted=1, sticky until reset. All enables are 0 and both counters freeze.
- ERR: error=1, sticky until reset. Enables are 0 and counters freeze. is_halted stays 0.
- Counters:
  - cycle_count increments every post-reset cycle whose state is IF..WB.
  - retire_count increments on each cycle that is marked "retire".
  - Both wrap modulo 2^CNT_WIDTH.
- Reset mid-instruction: the FSM aborts immediately; no partial pc_write or reg_write occurs after reset assertion.

Test Plan:
- add (0110011), mem_ready=1 in the IF cycle -> states IF,ID,EX,WB,IF over 4 cycles; reg_write=1 only in WB; retire_count=1; cycle_count=4.
- lw (0000011), mem_ready delayed 3 cycles in both IF and MEM -> IF lasts 4 cycles, MEM lasts 4 cycles, then WB with wb_sel=1; retire_count=1; error=0.
- beq with bcond=1 -> EX asserts pc_write=1, pc_source=1, returns to IF; with bcond=0, pc_source=0.
- ecall with halt_req=1 -> HALT after ID, is_halted=1, counters frozen for 10 further cycles, retire_count unchanged; ecall with halt_req=0 retires as nop.
- mem_ready held 0 in IF, MEM_TIMEOUT=15 -> ERR entered exactly 15 cycles after IF entry, error=1; opcode 0000000 in ID -> ERR next cycle.
- reset pulled low during MEM of a store -> mem_write drops to 0 asynchronously; after release state=IF, both counters=0.
